// File: rtl/ws_pkg.sv
// Shared definitions for the weight-stationary array: op_sel encodings
// (also used by the PE), the feeder FSM state type and the drain length.
package ws_pkg;

  localparam logic PRELOAD_OP = 1'b0;  // PE shifts weights down one row
  localparam logic CONV_OP    = 1'b1;  // PE holds weights and accumulates

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRELOAD,
    ST_STREAM,
    ST_DRAIN,
    ST_DONE
  } ws_state_e;

  // Cycles for the last injected vector to clear the array: it has to
  // cross the skew plus the full row/column extent of the grid.
  function automatic int unsigned drain_cyc(input int unsigned rows,
                                            input int unsigned cols);
    return rows + cols - 1;
  endfunction

endpackage

// File: rtl/ws_skew_line.sv
// DEPTH-stage shift register carrying one fmap word plus its valid tag.
// Every stage clears to zero on reset so no stale tag can leak into the
// array after an aborted job.
//   clk   in   clock
//   rst   in   asynchronous active-low reset
//   din   in   {tag, word} entering the line
//   dout  out  {tag, word} delayed by DEPTH cycles
module ws_skew_line #(
  parameter int DEPTH        = 1,
  parameter int in_word_size = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [in_word_size:0] din,
  output logic [in_word_size:0] dout
);

  logic [in_word_size:0] stage_q [DEPTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign dout = stage_q[DEPTH-1];

endmodule

// File: rtl/ws_array_feeder.sv
// Input-side sequencer for the weight-stationary systolic array. Preloads
// ROWS kernel rows through the top edge, then streams fmap vectors into the
// left edge with a per-row skew, drains the array and pulses done.
//
// Optional feature macro: WS_FEEDER_KERNEL_REUSE_EN adds reuse_kernel, which
// lets a job skip PRELOAD and reuse the weights already in the array.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   start, num_vectors        job launch (sampled in IDLE only) and length
//   reuse_kernel              (macro only) skip preload for this job
//   kern_data/valid/ready     kernel row handshake, word c -> column c
//   fmap_data/valid/ready     fmap vector handshake, word r -> row r
//   kernel_out, op_sel        top-edge kernel bus and broadcast PE opcode
//   fmap_out, fmap_tag        skewed left-edge data bus and per-row tags
//   busy, done                job active, one-cycle end-of-job pulse
//
// state      | meaning
// -----------+-------------------------------------------------------------
// ST_IDLE    | waiting for start
// ST_PRELOAD | accepting ROWS kernel rows, op_sel pulses low per transfer
// ST_STREAM  | accepting num_vectors fmap vectors into the skew lines
// ST_DRAIN   | injecting bubbles until the last partial sums leave
// ST_DONE    | done pulse, back to idle
module ws_array_feeder
  import ws_pkg::*;
#(
  parameter int ROWS         = 4,
  parameter int COLS         = 4,
  parameter int in_word_size = 16,
  parameter int CNT_W        = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic [CNT_W-1:0]             num_vectors,
`ifdef WS_FEEDER_KERNEL_REUSE_EN
  input  logic                         reuse_kernel,
`endif
  input  logic [COLS*in_word_size-1:0] kern_data,
  input  logic                         kern_valid,
  output logic                         kern_ready,
  input  logic [ROWS*in_word_size-1:0] fmap_data,
  input  logic                         fmap_valid,
  output logic                         fmap_ready,
  output logic [COLS*in_word_size-1:0] kernel_out,
  output logic                         op_sel,
  output logic [ROWS*in_word_size-1:0] fmap_out,
  output logic [ROWS-1:0]              fmap_tag,
  output logic                         busy,
  output logic                         done
);

  localparam int DW        = in_word_size;
  localparam int SW        = DW + 1;
  localparam int DRAIN_CYC = drain_cyc(ROWS, COLS);

  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
  localparam logic [CNT_W-1:0] KROW_LAST  = CNT_W'(ROWS - 1);
  localparam logic [CNT_W-1:0] DRAIN_LAST = CNT_W'(DRAIN_CYC - 1);

  ws_state_e          state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;     // down-counter, meaning depends on state
  logic [CNT_W-1:0]   num_q, num_d;     // latched num_vectors
  logic               kern_ready_q, fmap_ready_q, busy_q, done_q, op_sel_q;
  logic [COLS*DW-1:0] kernel_q;

  logic reuse_w;
`ifdef WS_FEEDER_KERNEL_REUSE_EN
  assign reuse_w = reuse_kernel;
`else
  assign reuse_w = 1'b0;
`endif

  logic kern_xfer, fmap_xfer;
  assign kern_xfer = kern_valid & kern_ready_q;
  assign fmap_xfer = fmap_valid & fmap_ready_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    num_d   = num_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          num_d = num_vectors;
          if (!reuse_w) begin
            state_d = ST_PRELOAD;
            cnt_d   = KROW_LAST;
          end else if (num_vectors == '0) begin
            state_d = ST_DRAIN;
            cnt_d   = DRAIN_LAST;
          end else begin
            state_d = ST_STREAM;
            cnt_d   = num_vectors - CNT_ONE;
          end
        end
      end
      ST_PRELOAD: begin
        if (kern_xfer) begin
          if (cnt_q == '0) begin
            if (num_q == '0) begin
              state_d = ST_DRAIN;
              cnt_d   = DRAIN_LAST;
            end else begin
              state_d = ST_STREAM;
              cnt_d   = num_q - CNT_ONE;
            end
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      ST_STREAM: begin
        if (fmap_xfer) begin
          if (cnt_q == '0) begin
            state_d = ST_DRAIN;
            cnt_d   = DRAIN_LAST;
          end else begin
            cnt_d = cnt_q - CNT_ONE;
          end
        end
      end
      ST_DRAIN: begin
        if (cnt_q == '0) state_d = ST_DONE;
        else             cnt_d   = cnt_q - CNT_ONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake/status flags are registered from the next state so they line
  // up exactly with state_q without a decode path on the outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      num_q        <= '0;
      kern_ready_q <= 1'b0;
      fmap_ready_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      op_sel_q     <= CONV_OP;
      kernel_q     <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      num_q        <= num_d;
      kern_ready_q <= (state_d == ST_PRELOAD);
      fmap_ready_q <= (state_d == ST_STREAM);
      busy_q       <= (state_d != ST_IDLE);
      done_q       <= (state_d == ST_DONE);
      // op_sel drops only alongside a fresh kernel row, so stalls never shift.
      op_sel_q     <= kern_xfer ? PRELOAD_OP : CONV_OP;
      if (kern_xfer) kernel_q <= kern_data;
    end
  end

  // Fmap skew: row r sees r extra stages, then a common output register.
  logic [SW-1:0] inj    [ROWS];
  logic [SW-1:0] skewed [ROWS];
  logic [SW-1:0] out_q  [ROWS];

  for (genvar r = 0; r < ROWS; r++) begin : g_row
    assign inj[r] = fmap_xfer ? {1'b1, fmap_data[r*DW +: DW]} : '0;
    if (r == 0) begin : g_wire
      assign skewed[r] = inj[r];
    end else begin : g_skew
      ws_skew_line #(
        .DEPTH       (r),
        .in_word_size(DW)
      ) u_skew (
        .clk (clk),
        .rst (rst),
        .din (inj[r]),
        .dout(skewed[r])
      );
    end
    assign fmap_out[r*DW +: DW] = out_q[r][DW-1:0];
    assign fmap_tag[r]          = out_q[r][DW];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int r = 0; r < ROWS; r++) out_q[r] <= '0;
    end else begin
      for (int r = 0; r < ROWS; r++) out_q[r] <= skewed[r];
    end
  end

  assign kern_ready = kern_ready_q;
  assign fmap_ready = fmap_ready_q;
  assign kernel_out = kernel_q;
  assign op_sel     = op_sel_q;
  assign busy       = busy_q;
  assign done       = done_q;

endmodule

// File: tb/tb_ws_array_feeder.sv
module tb_ws_array_feeder;

  localparam int ROWS      = 4;
  localparam int COLS      = 4;
  localparam int W         = 16;
  localparam int CNT_W     = 16;
  localparam int KW        = COLS * W;
  localparam int FW        = ROWS * W;
  localparam int DRAIN_CYC = ROWS + COLS - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic [CNT_W-1:0] num_vectors = '0;
  logic [KW-1:0]    kern_data = '0;
  logic             kern_valid = 1'b0;
  logic             kern_ready;
  logic [FW-1:0]    fmap_data = '0;
  logic             fmap_valid = 1'b0;
  logic             fmap_ready;
  logic [KW-1:0]    kernel_out;
  logic             op_sel;
  logic [FW-1:0]    fmap_out;
  logic [ROWS-1:0]  fmap_tag;
  logic             busy;
  logic             done;
`ifdef WS_FEEDER_KERNEL_REUSE_EN
  logic             reuse_kernel = 1'b0;
`endif

  ws_array_feeder dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .num_vectors(num_vectors),
`ifdef WS_FEEDER_KERNEL_REUSE_EN
    .reuse_kernel(reuse_kernel),
`endif
    .kern_data  (kern_data),
    .kern_valid (kern_valid),
    .kern_ready (kern_ready),
    .fmap_data  (fmap_data),
    .fmap_valid (fmap_valid),
    .fmap_ready (fmap_ready),
    .kernel_out (kernel_out),
    .op_sel     (op_sel),
    .fmap_out   (fmap_out),
    .fmap_tag   (fmap_tag),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Scoreboard queues: expected value plus the cycle it must appear in.
  typedef struct { logic [KW-1:0] d; int cyc; } kexp_t;
  typedef struct { int row; logic [W-1:0] d; int cyc; } fexp_t;
  kexp_t kq[$];
  fexp_t fq[$];
  int    dq[$];
  bit    prev_done = 1'b0;
  int    fready_cycles = 0;

  always @(negedge clk) begin
    if (rst) begin
      if (fmap_ready) fready_cycles++;
      if (!op_sel) begin
        if (kq.size() == 0) check("op_sel_spurious_low", op_sel, 1'b1);
        else begin
          kexp_t k;
          k = kq.pop_front();
          check("kernel_out", kernel_out, k.d);
          check("op_sel_cycle", cyc, k.cyc);
        end
      end
      for (int r = 0; r < ROWS; r++) begin
        if (fmap_tag[r]) begin
          int idx;
          idx = -1;
          for (int i = 0; i < fq.size(); i++)
            if (idx < 0 && fq[i].row == r) idx = i;
          if (idx < 0) check("fmap_tag_spurious", fmap_tag[r], 1'b0);
          else begin
            check("fmap_out_data", fmap_out[r*W +: W], fq[idx].d);
            check("fmap_out_cycle", cyc, fq[idx].cyc);
            fq.delete(idx);
          end
        end else if (fmap_out[r*W +: W] != '0) begin
          check("bubble_data", fmap_out[r*W +: W], '0);
        end
      end
      if (done) begin
        if (dq.size() == 0) check("done_spurious", done, 1'b0);
        else check("done_cycle", cyc, dq.pop_front());
        check("busy_during_done", busy, 1'b1);
      end
      if (prev_done) check("busy_after_done", busy, 1'b0);
      prev_done = done;
    end else begin
      prev_done = 1'b0;
    end
  end

  function automatic logic [KW-1:0] krow(input int k);
    logic [KW-1:0] v;
    for (int c = 0; c < COLS; c++) v[c*W +: W] = W'((c << 8) | (k + 1));
    return v;
  endfunction

  function automatic logic [FW-1:0] fvec(input int base);
    logic [FW-1:0] v;
    for (int r = 0; r < ROWS; r++) v[r*W +: W] = W'(base + r);
    return v;
  endfunction

  task automatic check_reset_outputs(input string tag);
    check({tag, "_kernel_out"}, kernel_out, '0);
    check({tag, "_op_sel"},     op_sel, 1'b1);
    check({tag, "_fmap_out"},   fmap_out, '0);
    check({tag, "_fmap_tag"},   fmap_tag, '0);
    check({tag, "_kern_ready"}, kern_ready, 1'b0);
    check({tag, "_fmap_ready"}, fmap_ready, 1'b0);
    check({tag, "_busy"},       busy, 1'b0);
    check({tag, "_done"},       done, 1'b0);
  endtask

  task automatic do_start(input int n);
    start = 1'b1;
    num_vectors = CNT_W'(n);
    @(negedge clk);
    start = 1'b0;
    num_vectors = CNT_W'(9);
    check("preload_entry_kern_ready", kern_ready, 1'b1);
    check("preload_entry_fmap_ready", fmap_ready, 1'b0);
  endtask

  task automatic send_kern(input logic [KW-1:0] d, output int acc);
    int guard;
    guard = 0;
    acc = -1;
    kern_data = d;
    kern_valid = 1'b1;
    while (acc < 0 && guard < 100) begin
      if (kern_ready) begin
        acc = cyc;
        kq.push_back('{d, cyc + 1});
      end
      @(negedge clk);
      guard++;
    end
    kern_valid = 1'b0;
    if (acc < 0) check("kern_handshake_timeout", kern_ready, 1'b1);
  endtask

  task automatic send_fmap(input logic [FW-1:0] d, output int acc);
    int guard;
    guard = 0;
    acc = -1;
    fmap_data = d;
    fmap_valid = 1'b1;
    while (acc < 0 && guard < 100) begin
      if (fmap_ready) begin
        acc = cyc;
        for (int r = 0; r < ROWS; r++) fq.push_back('{r, d[r*W +: W], cyc + 1 + r});
      end
      @(negedge clk);
      guard++;
    end
    fmap_valid = 1'b0;
    fmap_data = '0;
    if (acc < 0) check("fmap_handshake_timeout", fmap_ready, 1'b1);
  endtask

  task automatic wait_done();
    int guard;
    guard = 0;
    while (dq.size() != 0 && guard < 60) begin
      @(negedge clk);
      guard++;
    end
    check("done_pending_after_timeout", dq.size(), 0);
    repeat (2) @(negedge clk);
    check("fmap_queue_drained", fq.size(), 0);
    check("kern_queue_drained", kq.size(), 0);
  endtask

  // noise: during streaming, hold start and kern_valid high; both must be ignored.
  task automatic run_job(input int n, input int kgap, input int fgap, input int vbase, input bit noise);
    int t, last;
    do_start(n);
    last = -1;
    for (int k = 0; k < ROWS; k++) begin
      send_kern(krow(k), t);
      last = t;
      if (k < ROWS - 1) repeat (kgap) @(negedge clk);
    end
    check("kern_ready_drop", kern_ready, 1'b0);
    if (noise) begin
      start = 1'b1;
      num_vectors = CNT_W'(9);
      kern_data = {COLS{16'hdead}};
      kern_valid = 1'b1;
    end
    for (int v = 0; v < n; v++) begin
      send_fmap(fvec(vbase + 4 * v), t);
      last = t;
      if (noise) kern_valid = 1'b1;
      repeat (fgap) @(negedge clk);
    end
    start = 1'b0;
    kern_valid = 1'b0;
    dq.push_back(last + DRAIN_CYC + 1);
    wait_done();
  endtask

  initial begin
    int t, snap;
    repeat (3) @(negedge clk);
    #1;
    check_reset_outputs("reset");
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // back-to-back preload and stream
    run_job(3, 0, 0, 10, 1'b0);
    // second job right after: toggled kernel valid, gapped fmaps, ignored noise
    run_job(2, 1, 1, 100, 1'b1);
    // empty job: preload then straight to drain, fmap_ready never high
    snap = fready_cycles;
    run_job(0, 0, 0, 0, 1'b0);
    check("fmap_ready_never_in_empty_job", fready_cycles, snap);

    // abort mid-stream after one of three vectors
    do_start(3);
    for (int k = 0; k < ROWS; k++) send_kern(krow(k + 4), t);
    send_fmap(fvec(40), t);
    #1;
    rst = 1'b0;
    #1;
    check_reset_outputs("abort");
    kq.delete();
    fq.delete();
    dq.delete();
    @(negedge clk);
    #1;
    check_reset_outputs("abort_hold");
    @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check("idle_after_abort", busy, 1'b0);
    // next job must start at PRELOAD and complete
    run_job(1, 0, 0, 60, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1);
  end

endmodule

// File: doc/ws_array_feeder.md
Name: ws_array_feeder

Overview:
- Input-side sequencer for the weight-stationary systolic array.
- Accepts kernel row vectors and fmap vectors from the operand buffers over valid/ready handshakes.
- Drives the array's top-edge kernel bus, left-edge skewed fmap bus and broadcast op_sel, so a grid of WS_PE cells preloads weights and then convolves.
- Counts the drain period and pulses done once the last partial sums have left the array.

Parameters:
- ROWS, 4, array rows; also fmap vector length and number of kernel rows preloaded.
- COLS, 4, array columns; also kernel row vector length.
- in_word_size, 16, width of each fmap and kernel word.
- CNT_W, 16, width of the fmap vector count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous active-low reset.
- start  in  1  begin a job; sampled only in IDLE.
- num_vectors  in  CNT_W  number of fmap vectors in the job; sampled with start.
- kern_data  in  COLS*in_word_size  one kernel row; word c goes to column c.
- kern_valid  in  1  kern_data valid.
- kern_ready  out  1  feeder accepts a kernel row.
- fmap_data  in  ROWS*in_word_size  one fmap vector; word r goes to row r.
- fmap_valid  in  1  fmap_data valid.
- fmap_ready  out  1  feeder accepts an fmap vector.
- kernel_out  out  COLS*in_word_size  to kernel_in of row-0 PEs.
- op_sel  out  1  broadcast to all PEs: 0 = preload shift, 1 = conv/hold.
- fmap_out  out  ROWS*in_word_size  to fmap_in of column-0 PEs, skewed.
- fmap_tag  out  ROWS  per-row valid tag, skewed identically to fmap_out.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at job end.

Behaviour:
- Reset (asynchronous, rst low): state IDLE, all counters 0. Outputs: kernel_out = 0, op_sel = 1, fmap_out = 0, fmap_tag = 0, kern_ready = 0, fmap_ready = 0, busy = 0, done = 0. All skew registers are cleared. Reset mid-job aborts the job; no done pulse.
- FSM states: IDLE, PRELOAD, STREAM, DRAIN, DONE.
- IDLE: start = 1 latches num_vectors, goes to PRELOAD.
- PRELOAD:
  - kern_ready = 1; a transfer occurs when kern_valid & kern_ready.
  - On each transfer cycle, kernel_out <= kern_data and op_sel <= 0 (both registered, same edge). Every other cycle, op_sel <= 1, so stalls never shift weights.
  - The k-th accepted row (k = 0..ROWS-1) ends up in array row ROWS-1-k. Upstream supplies rows bottom-first.
  - After the ROWS-th transfer: go to STREAM, or to DRAIN if num_vectors == 0.
- STREAM:
  - fmap_ready = 1; a transfer occurs when fmap_valid & fmap_ready.
  - Word r of an accepted vector appears on fmap_out row r exactly 1 + r cycles after the accept edge, with fmap_tag[r] = 1.
  - A cycle with no transfer injects zero data with tag 0 into the skew lines (a bubble). Skew lines shift every cycle.
  - op_sel = 1 throughout.
  - After the num_vectors-th transfer, go to DRAIN.
- DRAIN: no ready asserted. Count DRAIN_CYC = ROWS + COLS - 1 cycles, injecting zero bubbles, then go to DONE.
- DONE: done = 1 for one cycle, then IDLE. busy drops in the same cycle the state returns to IDLE.
- kernel_out holds its last value outside transfer cycles.
- Count width: num_vectors up to 2^CNT_W - 1; the counter does not wrap within a job.
- Simultaneous events:
  - start while busy: ignored.
  - kern_valid and fmap_valid both high: only the one whose ready is asserted transfers.
  - kern_valid outside PRELOAD: ignored (ready = 0).

Optional Feature:
- Macro WS_FEEDER_KERNEL_REUSE_EN.
- Defined: adds input port reuse_kernel (1 bit), sampled with start. If it is 1, PRELOAD is skipped and the FSM goes IDLE -> STREAM, keeping the weights already stationary in the array. If num_vectors == 0, it goes IDLE -> DRAIN.
- Undefined: no port; every job preloads.

Decomposition:
- Shared package ws_pkg holds:
  - the PRELOAD_OP = 0 and CONV_OP = 1 op_sel encodings, shared with the PE;
  - the FSM state enum;
  - the DRAIN_CYC function of ROWS and COLS.
- One sub-module: ws_skew_line (parameter DEPTH, width in_word_size + 1 for data plus tag), a DEPTH-stage reset-to-zero shift register.
- The feeder instantiates ws_skew_line with DEPTH = r for row r; row 0 is a wire. The 1-cycle output register is common to all rows.

Test Plan:
- ROWS = COLS = 4, start with num_vectors = 3, kernel rows 0x0001.., 0x0002.., 0x0003.., 0x0004.. with no stalls -> op_sel low for exactly 4 consecutive cycles; kernel_out carries those rows in order; kern_ready drops after the 4th transfer.
- Kernel valid toggling 1,0,1,0,... -> op_sel low only on the cycle after each transfer and high otherwise; 4 low cycles total.
- fmap vector {r0 = 10, r1 = 11, r2 = 12, r3 = 13} accepted at cycle T -> fmap_out row r equals 10 + r with tag 1 at cycle T + 1 + r; all other rows show tag 0 in those cycles.
- 3 back-to-back fmap vectors, then none -> done pulses exactly 1 cycle after DRAIN_CYC = 7 drain cycles; busy low the next cycle; a second start then works.
- num_vectors = 0 -> PRELOAD, DRAIN (7 cycles), done; fmap_ready never asserted.
- rst low during STREAM after 1 of 3 vectors -> all outputs reach their reset values immediately; no done pulse; the next start begins at PRELOAD.
